// File: rtl/reg_file_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_pkg
// Description : Shared defaults, address-width helper and register typedefs
//               for the scoreboarded register file.
// Revision    : 1.0 - initial release
// ============================================================================
package reg_file_pkg;

  localparam int DATA_W_DEFAULT = 64;
  localparam int DEPTH_DEFAULT  = 32;

  // Register 0 is hard-wired to zero and can never be reserved.
  localparam int ZERO_REG = 0;

  // Address width for a given register count. The result is never below 1 bit.
  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int ADDR_W_DEFAULT = addr_w(DEPTH_DEFAULT);

  typedef logic [ADDR_W_DEFAULT-1:0] reg_addr_t;
  typedef logic [DATA_W_DEFAULT-1:0] reg_data_t;

endpackage
`default_nettype wire

// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : reg_scoreboard
// Description : Per-register busy tracking for long-latency results, with a
//               registered pending count and a sticky WAW error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_scoreboard
  import reg_file_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEFAULT,
  parameter int ADDR_W = addr_w(DEPTH)   // derived; leave at default
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic              wa_en,
  input  logic [ADDR_W-1:0] wa_addr,
  output logic [DEPTH-1:0]  busy,
  output logic [ADDR_W:0]   pend_cnt,
  output logic              waw_err
);

  localparam logic [ADDR_W-1:0] c_zero_addr = ADDR_W'(ZERO_REG);

  logic [DEPTH-1:0] busy_q, busy_d;
  logic [ADDR_W:0]  pend_q, pend_d;
  logic             waw_q,  waw_d;

  // Next busy vector: completion clears first, reservation sets after, so a
  // same-cycle reserve of a completing register leaves it busy.
  always_comb begin
    busy_d = busy_q;
    if (clr_en && clr_addr != c_zero_addr) busy_d[clr_addr] = 1'b0;
    if (rsv_en && rsv_addr != c_zero_addr) busy_d[rsv_addr] = 1'b1;
    busy_d[ZERO_REG] = 1'b0;
  end

  // Popcount of the next busy vector so the count lands on the same edge.
  always_comb begin
    pend_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      pend_d = pend_d + (ADDR_W+1)'(busy_d[i]);
    end
  end

  // Sticky flag: an in-order write hit a register still awaiting a late result.
  always_comb begin
    waw_d = waw_q | (wa_en && (wa_addr != c_zero_addr) && busy_q[wa_addr]);
  end

  // Scoreboard state, cleared asynchronously (pending reservations are lost).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q <= '0;
      pend_q <= '0;
      waw_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      pend_q <= pend_d;
      waw_q  <= waw_d;
    end
  end

  assign busy     = busy_q;
  assign pend_cnt = pend_q;
  assign waw_err  = waw_q;

endmodule
`default_nettype wire

// File: rtl/reg_file_sb.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_sb
// Description : Register file with NUM_RD combinational read ports, an
//               in-order write port (A), a handshaked late write port (B),
//               optional write-to-read forwarding and result scoreboarding.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int DEPTH  = DEPTH_DEFAULT,
  parameter int NUM_RD = 2,
  parameter int BYPASS = 1,
  parameter int ADDR_W = addr_w(DEPTH)   // derived; leave at default
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wa_en,
  input  logic [ADDR_W-1:0]        wa_addr,
  input  logic [DATA_W-1:0]        wa_data,
  input  logic                     wb_valid,
  output logic                     wb_ready,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic [ADDR_W:0]          pend_cnt,
  output logic                     waw_err
);

  localparam logic [ADDR_W-1:0] c_zero_addr = ADDR_W'(ZERO_REG);
  localparam logic              c_bypass    = (BYPASS != 0);

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic              wb_xfer;
  logic              wa_write;
  logic              wb_write;
  logic              fwd_en;

  // Port A has strict priority; port B is only accepted on idle A cycles.
  assign wb_ready = ~wa_en;
  assign wb_xfer  = wb_valid & wb_ready;
  assign wa_write = wa_en   & (wa_addr != c_zero_addr);
  assign wb_write = wb_xfer & (wb_addr != c_zero_addr);

  // Forwarding is suppressed while in reset so reads stay at zero.
  assign fwd_en = c_bypass & reset_n;

  // Data array; the two write ports are mutually exclusive by the handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wa_write) begin
      regs_q[wa_addr] <= wa_data;
    end else if (wb_write) begin
      regs_q[wb_addr] <= wb_data;
    end
  end

  reg_scoreboard #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk      (clk),
    .reset_n  (reset_n),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .clr_en   (wb_xfer),
    .clr_addr (wb_addr),
    .wa_en    (wa_en),
    .wa_addr  (wa_addr),
    .busy     (busy),
    .pend_cnt (pend_cnt),
    .waw_err  (waw_err)
  );

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              bsy;

    assign addr = rd_addr[i*ADDR_W +: ADDR_W];

    // Read mux: stored value, optionally overridden by this cycle's write.
    // A forwarded late result reads as not busy unless re-reserved now.
    always_comb begin
      data = regs_q[addr];
      bsy  = busy[addr];
      if (addr == c_zero_addr) begin
        data = '0;
        bsy  = 1'b0;
      end else if (fwd_en) begin
        if (wa_write && (addr == wa_addr)) begin
          data = wa_data;
        end else if (wb_write && (addr == wb_addr)) begin
          data = wb_data;
          bsy  = rsv_en && (rsv_addr == addr);
        end
      end
    end

    assign rd_data[i*DATA_W +: DATA_W] = data;
    assign rd_busy[i]                  = bsy;
  end

endmodule
`default_nettype wire

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised successor of the core's register file, adding scoreboarding for long-latency results.
- Feeds the decode/issue stage of the classical controller. Provides NUM_RD combinational read ports and two write ports.
  - Port A: in-order pipeline write-back.
  - Port B: late write-back with a valid/ready handshake, e.g. measurement results returning from the quantum pipeline.
- A busy bit per register lets issue logic stall on pending results.

Parameters:
- DATA_W, 64, register width in bits
- DEPTH, 32, number of registers (power of two, ≥2)
- NUM_RD, 2, number of read ports
- BYPASS, 1, 1 = same-cycle write-to-read forwarding; 0 = reads return pre-write value
- ADDR_W, $clog2(DEPTH), derived, not overridden

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset_n  in  1  asynchronous active-low reset
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses, port i at [i*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  packed read data
- rd_busy  out  NUM_RD  busy bit of addressed register
- wa_en  in  1  port A write enable
- wa_addr  in  ADDR_W  port A address
- wa_data  in  DATA_W  port A data
- wb_valid  in  1  port B write request
- wb_ready  out  1  port B accept
- wb_addr  in  ADDR_W  port B address
- wb_data  in  DATA_W  port B data
- rsv_en  in  1  reserve register (set busy) for a pending port-B result
- rsv_addr  in  ADDR_W  register to reserve
- pend_cnt  out  ADDR_W+1  number of busy registers
- waw_err  out  1  sticky: port A wrote a busy register

Behaviour:
- Reset (reset_n=0, asynchronous):
  - All registers clear to 0, all busy bits to 0, pend_cnt=0, waw_err=0.
  - Reads during reset return 0.
  - Any in-flight reservation is lost; a later wb completion to that address is a plain write.
- Register 0:
  - Always reads 0 and is never busy.
  - Writes, reservations and wb to address 0 are ignored; wb still handshakes.
- Reads:
  - Combinational: rd_data[i] = regs[rd_addr[i]], rd_busy[i] = busy[rd_addr[i]].
- Port A:
  - wa_en=1 writes wa_data at the clock edge, with no handshake.
  - If the target is busy: the data is written, the busy bit is unchanged, and waw_err is set. waw_err stays set until reset.
- Port B:
  - wb_ready = !wa_en (combinational); port A has strict priority.
  - A transfer occurs when wb_valid && wb_ready. On transfer, wb_data is written and the busy bit of wb_addr is cleared.
  - The requester must hold wb_valid/addr/data stable until the transfer.
  - A wb transfer to a non-busy register is legal and behaves as a plain write.
- Reservation:
  - rsv_en=1 sets busy[rsv_addr] at the edge.
  - Reserving an already-busy register leaves it busy; pend_cnt does not double count.
  - If rsv_addr equals a completing wb_addr in the same cycle, set wins: the register is written and stays busy.
- BYPASS=1:
  - If rd_addr[i] equals the address being written this cycle (wa_en, or a wb transfer) and is nonzero, rd_data[i] returns the incoming data.
  - If the write is a wb transfer, rd_busy[i]=0 unless rsv_en targets the same address.
- BYPASS=0: reads always reflect pre-edge state.
- pend_cnt:
  - Registered popcount of the busy bits, updated the same edge as the busy vector.
  - Range 0..DEPTH-1, since register 0 is never busy.
- Latency:
  - Write to read-visible: 0 cycles with bypass, 1 cycle without.
  - Reserve to busy visible: 1 cycle, never bypassed.

Decomposition:
- Package reg_file_pkg holds:
  - DATA_W and DEPTH defaults
  - the derived ADDR_W function
  - typedefs reg_addr_t and reg_data_t
  - localparam ZERO_REG = 0
- Sub-module reg_scoreboard (parameter DEPTH):
  - Owns the busy vector, set/clear priority, pend_cnt popcount and waw_err.
  - The top level holds the data array, read muxes, bypass and the port-B handshake.

Test Plan:
- Reset then read all addresses -> rd_data=0, rd_busy=0, pend_cnt=0, waw_err=0. Write 0xDEAD to r0 via both ports -> r0 still reads 0.
- rsv r5; next cycle rd_busy(r5)=1, pend_cnt=1. wb r5=0x1234 accepted -> same cycle rd_data=0x1234, rd_busy=0 (BYPASS=1); next cycle pend_cnt=0.
- wa_en r3=0xA and wb_valid r7=0xB in the same cycle -> wb_ready=0, only r3 written. Next cycle wa_en=0 -> wb accepted, r7=0xB.
- rsv r9, then wa_en r9=0x55 -> r9=0x55, busy stays 1, waw_err=1 and stays 1 through later traffic until reset_n pulse.
- Simultaneous rsv r4 and wb completion r4=0x77 (r4 busy) -> r4=0x77, busy(r4)=1, pend_cnt unchanged.
- With r2,r6 reserved, assert reset_n=0 mid-cycle asynchronously -> outputs clear immediately. Later wb r2=0x9 -> written, pend_cnt=0. Repeat with BYPASS=0: a same-cycle read returns the old value.
